// File: rtl/pio_output_path.sv
// Single-cycle PIO state machine (JMP/SET subset) with per-pin FSM and
// per-core output arbitration feeding the GPIO pads.
module pio_output_path (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  output logic [4:0]  pc,
  output logic [31:0] x,
  output logic [31:0] y,
  output logic [31:0] fsm_pins,
  output logic [31:0] fsm_dirs,
  input  logic [31:0] fsm_output [3:0],
  input  logic [31:0] fsm_drive [3:0],
  output logic [31:0] fsm_core_output,
  output logic [31:0] fsm_core_drive,
  input  logic [1:0]  core_select [31:0],
  input  logic [31:0] core_output [3:0],
  input  logic [31:0] core_drive [3:0],
  output logic [31:0] gpio_output,
  output logic [31:0] gpio_drive
);

  localparam logic [2:0] OP_JMP = 3'b000;
  localparam logic [2:0] OP_SET = 3'b111;

  logic [4:0]  pc_r, pc_nxt_s;
  logic [31:0] x_r, x_nxt_s, y_r, y_nxt_s;
  logic [31:0] pins_r, pins_nxt_s, dirs_r, dirs_nxt_s;
  logic [2:0]  opcode_s, field_s;
  logic [4:0]  data_s;
  logic        jmp_take_s;
  logic        delay_unused_s;

  assign opcode_s       = instruction[15:13];
  assign field_s        = instruction[7:5];
  assign data_s         = instruction[4:0];
  // Delay/side-set field is reduced to a single bit that drives no logic.
  assign delay_unused_s = ^instruction[12:8];

  // Instruction decode and next-state computation.
  always_comb begin
    pc_nxt_s   = pc_r + 5'd1;
    x_nxt_s    = x_r;
    y_nxt_s    = y_r;
    pins_nxt_s = pins_r;
    dirs_nxt_s = dirs_r;
    jmp_take_s = 1'b0;
    case (opcode_s)
      OP_JMP: begin
        case (field_s)
          3'b000: jmp_take_s = 1'b1;
          3'b001: jmp_take_s = (x_r == 32'd0);
          3'b010: begin
            // Test uses the value before the unconditional decrement.
            jmp_take_s = (x_r != 32'd0);
            x_nxt_s    = x_r - 32'd1;
          end
          3'b011: jmp_take_s = (y_r == 32'd0);
          3'b100: begin
            jmp_take_s = (y_r != 32'd0);
            y_nxt_s    = y_r - 32'd1;
          end
          3'b101: jmp_take_s = (x_r != y_r);
          default: jmp_take_s = 1'b0;
        endcase
        if (jmp_take_s) begin
          pc_nxt_s = data_s;
        end else begin
          pc_nxt_s = pc_r + 5'd1;
        end
      end
      OP_SET: begin
        case (field_s)
          3'b000: pins_nxt_s = {pins_r[31:5], data_s};
          3'b001: x_nxt_s    = {27'd0, data_s};
          3'b010: y_nxt_s    = {27'd0, data_s};
          3'b100: dirs_nxt_s = {dirs_r[31:5], data_s};
          default: pins_nxt_s = pins_r;
        endcase
      end
      default: pc_nxt_s = pc_r + 5'd1;
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r   <= 5'd0;
      x_r    <= 32'd0;
      y_r    <= 32'd0;
      pins_r <= 32'd0;
      dirs_r <= 32'd0;
    end else begin
      pc_r   <= pc_nxt_s;
      x_r    <= x_nxt_s;
      y_r    <= y_nxt_s;
      pins_r <= pins_nxt_s;
      dirs_r <= dirs_nxt_s;
    end
  end

  assign pc       = pc_r;
  assign x        = x_r;
  assign y        = y_r;
  assign fsm_pins = pins_r;
  assign fsm_dirs = dirs_r;

  // FSM merge: later (higher-index) drivers overwrite earlier ones bitwise.
  always_comb begin
    fsm_core_output = 32'd0;
    fsm_core_drive  = 32'd0;
    for (int k = 0; k < 4; k++) begin
      fsm_core_output = (fsm_core_output & ~fsm_drive[k]) | (fsm_output[k] & fsm_drive[k]);
      fsm_core_drive  = fsm_core_drive | fsm_drive[k];
    end
  end

  // Per-pin core mux; value passes through regardless of the drive bit.
  always_comb begin
    gpio_output = 32'd0;
    gpio_drive  = 32'd0;
    for (int i = 0; i < 32; i++) begin
      gpio_output[i] = core_output[core_select[i]][i];
      gpio_drive[i]  = core_drive[core_select[i]][i];
    end
  end

endmodule

// File: tb/tb_pio_output_path.sv
// Self-checking bench: directed scenarios plus random instruction and
// arbitration traffic compared against a behavioural model.
module tb_pio_output_path;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        rst = 1'b0;
  logic [15:0] instruction = 16'd0;
  logic [4:0]  pc;
  logic [31:0] x, y, fsm_pins, fsm_dirs;
  logic [31:0] fsm_output [3:0];
  logic [31:0] fsm_drive [3:0];
  logic [31:0] fsm_core_output, fsm_core_drive;
  logic [1:0]  core_select [31:0];
  logic [31:0] core_output [3:0];
  logic [31:0] core_drive [3:0];
  logic [31:0] gpio_output, gpio_drive;

  int checks = 0;
  int errors = 0;

  // Reference state
  int unsigned m_pc;
  logic [31:0] m_x, m_y, m_pins, m_dirs;

  pio_output_path dut (
    .clk(clk), .rst(rst), .instruction(instruction), .pc(pc), .x(x), .y(y),
    .fsm_pins(fsm_pins), .fsm_dirs(fsm_dirs),
    .fsm_output(fsm_output), .fsm_drive(fsm_drive),
    .fsm_core_output(fsm_core_output), .fsm_core_drive(fsm_core_drive),
    .core_select(core_select), .core_output(core_output), .core_drive(core_drive),
    .gpio_output(gpio_output), .gpio_drive(gpio_drive)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_x = 32'd0; m_y = 32'd0; m_pins = 32'd0; m_dirs = 32'd0;
  endtask

  // Behavioural meaning of one instruction.
  task automatic model_step(input logic [15:0] ins);
    int unsigned op, f, d, target;
    bit taken;
    op = ins >> 13; f = (ins >> 5) & 7; d = ins & 31;
    target = (m_pc + 1) % 32;
    if (op == 0) begin
      taken = 0;
      if (f == 0) taken = 1;
      else if (f == 1) taken = (m_x == 0);
      else if (f == 2) begin taken = (m_x != 0); m_x = m_x - 32'd1; end
      else if (f == 3) taken = (m_y == 0);
      else if (f == 4) begin taken = (m_y != 0); m_y = m_y - 32'd1; end
      else if (f == 5) taken = (m_x != m_y);
      if (taken) target = d;
    end else if (op == 7) begin
      if (f == 1) m_x = d;
      else if (f == 2) m_y = d;
      else if (f == 0) m_pins = (m_pins & 32'hFFFF_FFE0) | d;
      else if (f == 4) m_dirs = (m_dirs & 32'hFFFF_FFE0) | d;
    end
    m_pc = target;
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".pc"}, {27'd0, pc}, m_pc);
    chk({tag, ".x"}, x, m_x);
    chk({tag, ".y"}, y, m_y);
    chk({tag, ".pins"}, fsm_pins, m_pins);
    chk({tag, ".dirs"}, fsm_dirs, m_dirs);
  endtask

  task automatic exec(input logic [15:0] ins, input string tag);
    instruction = ins;
    @(posedge clk);
    model_step(ins);
    #1;
    check_state(tag);
  endtask

  // Arbitration model: scan state machines from highest priority down.
  task automatic check_arb(input string tag);
    logic [31:0] e_out, e_drv, g_out, g_drv;
    e_out = 32'd0; e_drv = 32'd0; g_out = 32'd0; g_drv = 32'd0;
    for (int i = 0; i < 32; i++) begin
      for (int k = 3; k >= 0; k--) begin
        if (fsm_drive[k][i]) begin
          e_out[i] = fsm_output[k][i];
          e_drv[i] = 1'b1;
          break;
        end
      end
      g_out[i] = core_output[core_select[i]][i];
      g_drv[i] = core_drive[core_select[i]][i];
    end
    #1;
    chk({tag, ".fsm_out"}, fsm_core_output, e_out);
    chk({tag, ".fsm_drv"}, fsm_core_drive, e_drv);
    chk({tag, ".gpio_out"}, gpio_output, g_out);
    chk({tag, ".gpio_drv"}, gpio_drive, g_drv);
  endtask

  task automatic randomize_arb();
    for (int k = 0; k < 4; k++) begin
      fsm_output[k] = $urandom; fsm_drive[k] = $urandom & $urandom;
      core_output[k] = $urandom; core_drive[k] = $urandom;
    end
    for (int i = 0; i < 32; i++) core_select[i] = 2'($urandom_range(0, 3));
  endtask

  initial begin
    logic [15:0] ins;
    for (int k = 0; k < 4; k++) begin
      fsm_output[k] = 32'd0; fsm_drive[k] = 32'd0;
      core_output[k] = 32'd0; core_drive[k] = 32'd0;
    end
    for (int i = 0; i < 32; i++) core_select[i] = 2'd0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    rst = 1'b1;

    // NOP counting with wrap
    for (int i = 0; i < 33; i++) begin
      exec(16'hA042, "nop");
      chk("nop_pc_seq", {27'd0, pc}, (i + 1) % 32);
    end
    chk("nop_x", x, 32'd0);
    chk("nop_y", y, 32'd0);

    // JMP X-- loop
    exec(16'hE027, "set_x7");
    for (int i = 0; i < 8; i++) exec(16'h0045, "jmp_xdec");
    chk("xdec_pc_final", {27'd0, pc}, 32'd6);
    chk("xdec_x_final", x, 32'hFFFF_FFFF);

    // X!=Y jump and SET PINS
    exec(16'hE043, "set_y3");
    exec(16'hE020, "set_x0");
    exec(16'h00B4, "jmp_xney");
    chk("xney_pc", {27'd0, pc}, 32'd20);
    exec(16'hE015, "set_pins");
    chk("pins_val", fsm_pins, 32'h0000_0015);
    exec(16'hE09A, "set_dirs");
    chk("dirs_val", fsm_dirs, 32'h0000_001A);

    // FSM arbitration directed
    fsm_drive[0] = 32'h0F; fsm_output[0] = 32'h05;
    fsm_drive[1] = 32'hF0; fsm_output[1] = 32'hA0;
    #1;
    chk("arb_out", fsm_core_output, 32'h0000_00A5);
    chk("arb_drv", fsm_core_drive, 32'h0000_00FF);
    fsm_drive[3] = 32'h80; fsm_output[3] = 32'h00;
    #1;
    chk("arb_prio", fsm_core_output, 32'h0000_0025);

    // Core arbitration directed
    for (int i = 0; i < 32; i++) core_select[i] = 2'd2;
    core_output[2] = 32'hDEAD_BEEF; core_drive[2] = 32'hFFFF_0000;
    #1;
    chk("core_out", gpio_output, 32'hDEAD_BEEF);
    chk("core_drv", gpio_drive, 32'hFFFF_0000);
    core_select[0] = 2'd0; core_output[0] = 32'd0;
    #1;
    chk("core_pin0", {31'd0, gpio_output[0]}, 32'd0);

    // Async reset with clock stopped
    for (int i = 0; i < 4; i++) exec(16'hE029 + 16'(i), "pre_rst");
    clk_en = 1'b0;
    rst = 1'b0;
    #3;
    model_reset();
    check_state("async_rst");
    chk("rst_comb_out", fsm_core_output, 32'h0000_0025);
    #2;
    rst = 1'b1;
    #1;
    clk_en = 1'b1;
    exec(16'hA042, "post_rst");
    chk("post_rst_pc", {27'd0, pc}, 32'd1);

    // Random instruction + arbitration traffic
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 3))
        0: ins = {3'b000, 5'($urandom), 3'($urandom), 5'($urandom)};
        1: ins = {3'b111, 5'($urandom), 3'($urandom), 5'($urandom)};
        2: ins = {3'b000, 5'd0, 3'($urandom_range(1, 5)), 5'($urandom)};
        default: ins = 16'($urandom);
      endcase
      exec(ins, "rand_sm");
      randomize_arb();
      check_arb("rand_arb");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
